latched_priority_encoder: RTL and testbench



---
 rtl/latched_priority_encoder_if.sv | 32 +++
 rtl/latched_priority_encoder.sv | 124 ++++++++++++
 tb/tb_latched_priority_encoder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/latched_priority_encoder_if.sv
// rtl/latched_priority_encoder_if.sv - request/issue bundle for the latched priority encoder
//
// Signals:
//   enable     master->slave  sample req this cycle when 1
//   req        master->slave  request lines, bit i requests address i
//   out_ready  master->slave  consumer accepts the issued address
//   out_valid  slave->master  address/multi are valid
//   address    slave->master  binary index of the issued request
//   multi      slave->master  more than one bit was pending at selection
//   pending    slave->master  current pending register (status/debug)
interface latched_priority_encoder_if #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2
);
    logic              enable;
    logic [WIDTH-1:0]  req;
    logic              out_ready;
    logic              out_valid;
    logic [ADDR_W-1:0] address;
    logic              multi;
    logic [WIDTH-1:0]  pending;

    modport master (
        output enable, req, out_ready,
        input  out_valid, address, multi, pending
    );

    modport slave (
        input  enable, req, out_ready,
        output out_valid, address, multi, pending
    );
endinterface

// File: rtl/latched_priority_encoder.sv
// rtl/latched_priority_encoder.sv - sticky request capture with lowest-index-first binary issue
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    latched_priority_encoder_if.slave (enable/req/out_ready in,
//          out_valid/address/multi/pending out)
//
// Request bits accumulate in a sticky pending register. The lowest set
// index is issued over a valid/ready handshake and cleared once accepted.
// All outputs come straight from registers.
module latched_priority_encoder #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    latched_priority_encoder_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  pending_q;
    logic [WIDTH-1:0]  pending_d;
    logic [ADDR_W-1:0] address_q;
    logic              multi_q;

    logic              transfer;
    logic [WIDTH-1:0]  served;
    logic [WIDTH-1:0]  remaining;
    logic [WIDTH-1:0]  capture;
    logic              load;
    logic [ADDR_W-1:0] sel_address;
    logic              sel_multi;

    // Lowest set index wins; scanning downward lets the lowest overwrite.
    function automatic logic [ADDR_W-1:0] lowest_index(input logic [WIDTH-1:0] v);
        logic [ADDR_W-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ADDR_W'(i);
            end
        end
        return idx;
    endfunction

    assign transfer = bus.out_valid & bus.out_ready;
    assign served   = transfer ? (WIDTH'(1) << address_q) : '0;
    assign capture  = bus.enable ? bus.req : '0;

    // Selection never sees requests arriving on the same edge; served is
    // zero in IDLE, so this covers both states.
    assign remaining   = pending_q & ~served;
    assign sel_address = lowest_index(remaining);
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign sel_multi   = |(remaining & (remaining - WIDTH'(1)));

    // A new request on the served bit re-sets it: set wins over clear.
    assign pending_d = remaining | capture;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (transfer) begin
                    if (remaining != '0) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: pending accumulates every edge, address/multi
    // only change when a new selection is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            address_q <= '0;
            multi_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (load) begin
                address_q <= sel_address;
                multi_q   <= sel_multi;
            end
        end
    end

    // Output logic
    always_comb begin
        bus.out_valid = (state_q == HOLD);
        bus.address   = address_q;
        bus.multi     = multi_q;
        bus.pending   = pending_q;
    end

endmodule

// File: tb/tb_latched_priority_encoder.sv
// tb/tb_latched_priority_encoder.sv - directed and random checks of latched_priority_encoder
module tb_latched_priority_encoder;

    localparam int WIDTH  = 4;
    localparam int ADDR_W = 2;

    logic clk;
    logic rst_n;

    int compared;
    int mismatched;

    // Reference state: a set of pending indices and the offer in flight.
    int m_pend;
    bit m_valid;
    int m_addr;
    bit m_multi;

    latched_priority_encoder_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    latched_priority_encoder #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lowest(input int v);
        for (int i = 0; i < WIDTH; i++) begin
            if (((v >> i) & 1) == 1) return i;
        end
        return 0;
    endfunction

    function automatic int count_bits(input int v);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) n += (v >> i) & 1;
        return n;
    endfunction

    task automatic model_reset();
        m_pend  = 0;
        m_valid = 0;
        m_addr  = 0;
        m_multi = 0;
    endtask

    task automatic model_edge(input bit en, input int rq, input bit rdy);
        int  rest;
        bit  xfer;
        rest = m_pend;
        xfer = m_valid && rdy;
        if (xfer) rest = rest & ~(1 << m_addr);
        if (!m_valid || xfer) begin
            if (rest != 0) begin
                m_addr  = lowest(rest);
                m_multi = count_bits(rest) >= 2;
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
        end
        m_pend = rest | (en ? rq : 0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"},   32'(bus.out_valid), 32'(m_valid));
        check({tag, ".address"}, 32'(bus.address),   32'(m_addr));
        check({tag, ".multi"},   32'(bus.multi),     32'(m_multi));
        check({tag, ".pending"}, 32'(bus.pending),   32'(m_pend));
    endtask

    task automatic step(input string tag, input bit en, input int rq, input bit rdy);
        @(negedge clk);
        bus.enable    = en;
        bus.req       = WIDTH'(rq);
        bus.out_ready = rdy;
        @(posedge clk);
        model_edge(en, rq, rdy);
        #1;
        check_model(tag);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n         = 1'b0;
        bus.enable    = 1'b0;
        bus.req       = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single request
        step("single.e1", 1, 4'b0100, 1);
        step("single.e2", 0, 0, 1);
        check("single.addr2", 32'(bus.address), 32'd2);
        step("single.e3", 0, 0, 1);

        // Backpressure
        step("bp.cap", 1, 4'b1010, 0);
        for (int i = 0; i < 3; i++) step("bp.hold", 0, 0, 0);
        check("bp.held_addr", 32'(bus.address), 32'd1);
        check("bp.held_multi", 32'(bus.multi), 32'd1);
        step("bp.xfer1", 0, 0, 1);
        check("bp.next_addr", 32'(bus.address), 32'd3);
        step("bp.xfer3", 0, 0, 1);

        // Enable gating
        for (int i = 0; i < 5; i++) step("gate.off", 0, 4'b1111, 1);
        step("gate.on", 1, 4'b1111, 0);
        step("gate.issue", 0, 0, 0);
        check("gate.addr0", 32'(bus.address), 32'd0);
        for (int i = 0; i < 4; i++) step("gate.drain", 0, 0, 1);

        // Set wins on the served bit, one bubble before re-issue
        step("rereq.cap", 1, 4'b0001, 0);
        step("rereq.valid", 0, 0, 0);
        step("rereq.xfer", 1, 4'b0001, 1);
        check("rereq.pend0", 32'(bus.pending[0]), 32'd1);
        check("rereq.bubble", 32'(bus.out_valid), 32'd0);
        step("rereq.again", 0, 0, 0);
        step("rereq.drain", 0, 0, 1);

        // Full throughput
        step("tput.cap", 1, 4'b1111, 1);
        for (int i = 0; i < 4; i++) begin
            step("tput.seq", 0, 0, 1);
            check("tput.addr", 32'(bus.address), 32'(i));
            check("tput.multi", 32'(bus.multi), 32'(i < 3));
        end
        step("tput.end", 0, 0, 1);

        // Reset between edges mid-handshake
        step("rst.cap", 1, 4'b1111, 0);
        step("rst.valid", 0, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("rst.async");
        @(negedge clk);
        bus.req = '0;
        rst_n   = 1'b1;
        for (int i = 0; i < 3; i++) step("rst.quiet", 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0),
                 (($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 0),
                 1'($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
